pipe_hazard_ctrl: RTL

- Central stall, flush and hold sequencer for the 5-stage pipeline.
- Detects load-use hazards between IF/ID and ID/EX.
- Holds the EX/MEM register and the front end while a multi-cycle data memory access completes.
- Flushes the younger stages when the branch latched in EX/MEM resolves taken. Keeps saturating stall and flush statistics counters.
- State updates on posedge clk, so every control output is stable before the pipeline registers capture on negedge clk.

---
 rtl/pipe_hazard_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_if.sv
// Pipeline <-> hazard controller signal bundle: hazard inputs from the pipeline registers,
// stall/flush/hold controls and statistics back to the pipeline.
interface pipe_hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       IF_ID_RS1;
  logic [4:0]       IF_ID_RS2;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RD;
  logic             EX_MEM_Branch;
  logic             EX_MEM_ZERO;
  logic             EX_MEM_MemRead;
  logic             EX_MEM_MemWrite;
  logic             Mem_Ready;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Bubble;
  logic             Flush_IF_ID;
  logic             Flush_ID_EX;
  logic             Hold_EX_MEM;
  logic             Mem_Req;
  logic             Mem_Timeout;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  modport master (
    output IF_ID_RS1, IF_ID_RS2, ID_EX_MemRead, ID_EX_RD, EX_MEM_Branch, EX_MEM_ZERO,
           EX_MEM_MemRead, EX_MEM_MemWrite, Mem_Ready,
    input  PC_Write, IF_ID_Write, ID_EX_Bubble, Flush_IF_ID, Flush_ID_EX, Hold_EX_MEM,
           Mem_Req, Mem_Timeout, Stall_Count, Flush_Count
  );

  modport slave (
    input  IF_ID_RS1, IF_ID_RS2, ID_EX_MemRead, ID_EX_RD, EX_MEM_Branch, EX_MEM_ZERO,
           EX_MEM_MemRead, EX_MEM_MemWrite, Mem_Ready,
    output PC_Write, IF_ID_Write, ID_EX_Bubble, Flush_IF_ID, Flush_ID_EX, Hold_EX_MEM,
           Mem_Req, Mem_Timeout, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / hold sequencer for the 5-stage pipeline. Controls are decoded from the
// posedge-updated state plus current inputs so they settle before the negedge capture.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_LEN = 1,
  parameter int unsigned WAIT_MAX  = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_hazard_if.slave  hz
);

  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned FLUSH_W = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_tot_q;

  logic mem_op, taken, lu, flush_inc;
  logic pc_write, if_id_write, bubble, flush_if_id, flush_id_ex, hold_ex_mem, mem_req;

  assign mem_op = hz.EX_MEM_MemRead | hz.EX_MEM_MemWrite;
  assign taken  = hz.EX_MEM_Branch & hz.EX_MEM_ZERO;
  assign lu     = hz.ID_EX_MemRead && (hz.ID_EX_RD != 5'd0) &&
                  ((hz.ID_EX_RD == hz.IF_ID_RS1) || (hz.ID_EX_RD == hz.IF_ID_RS2));

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    flush_inc   = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    bubble      = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    hold_ex_mem = 1'b0;
    mem_req     = 1'b0;
    case (state_q)
      ST_RUN: begin
        mem_req = mem_op;
        if (mem_op && !hz.Mem_Ready) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          hold_ex_mem = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = WAIT_W'(1);
        end else if (taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          flush_inc   = 1'b1;
          if (FLUSH_LEN > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_W'(1);
          end
        end else if (lu) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          bubble      = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        mem_req     = 1'b1;
        hold_ex_mem = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if (hz.Mem_Ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(WAIT_MAX)) begin
          timeout_d  = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_FLUSH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        if (flush_cnt_d == FLUSH_W'(FLUSH_LEN)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_RUN;
        wait_cnt_d  = '0;
        flush_cnt_d = '0;
      end
    endcase
  end

  // State and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_tot_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_tot_q != '1)) flush_tot_q <= flush_tot_q + CNT_W'(1);
    end
  end

  // Controls fall back to idle values whenever reset is asserted
  assign hz.PC_Write     = pc_write | ~rst_n;
  assign hz.IF_ID_Write  = if_id_write | ~rst_n;
  assign hz.ID_EX_Bubble = bubble & rst_n;
  assign hz.Flush_IF_ID  = flush_if_id & rst_n;
  assign hz.Flush_ID_EX  = flush_id_ex & rst_n;
  assign hz.Hold_EX_MEM  = hold_ex_mem & rst_n;
  assign hz.Mem_Req      = mem_req & rst_n;
  assign hz.Mem_Timeout  = timeout_q;
  assign hz.Stall_Count  = stall_cnt_q;
  assign hz.Flush_Count  = flush_tot_q;

endmodule
